spi_slave_byte_if: RTL and testbench

- SPI mode-0 slave front end that sits directly upstream of spi_ctrl inside systolic_spi_wrapper.
- Synchronises the asynchronous sclk/mosi/cs_n pins into the clk domain and deserialises MOSI into bytes, which are handed to spi_ctrl.
- Serialises the controller-supplied response bytes onto MISO.
- Reports frame start, end and abort events.

---
 rtl/spi_slave_byte_if.sv | 226 ++++++++++++++++++++++
 tb/tb_spi_slave_byte_if.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_byte_if.sv
// SPI mode-0 slave byte front end: pin synchronisers, MOSI deserialiser, MISO serialiser and frame events.
// Define SPI_OVERRUN_DETECT_EN to build the sticky rx_overrun detector; otherwise rx_overrun is 0.
module spi_slave_byte_if #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = 8,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              cs_n,
    output logic              miso,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ack,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_req,
    output logic              frame_start,
    output logic              frame_end,
    output logic              frame_abort,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              rx_overrun
);

    localparam int                BIT_W     = $clog2(DATA_W);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam int                FILL_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cs_prev_q, cs_prev_d;
    logic [FILL_W-1:0]      fill_q, fill_d;
    logic                   armed_q, armed_d;
    logic [0:0]             state_q, state_d;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]      rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0]      tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0]      rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   tx_req_q, tx_req_d;
    logic                   frame_start_q, frame_start_d;
    logic                   frame_end_q, frame_end_d;
    logic                   frame_abort_q, frame_abort_d;
    logic [CNT_W-1:0]       word_cnt_q, word_cnt_d;

    logic              sclk_s, mosi_s, cs_s;
    logic              sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic              fill_done;
    logic [DATA_W-1:0] rx_next;
    logic              unused_rx_msb;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign fill_done = (fill_q == FILL_DONE);
    assign rx_next   = {rx_shift_q[DATA_W-2:0], mosi_s};
    assign unused_rx_msb = rx_shift_q[DATA_W-1];

    always_comb begin
        sclk_sync_d   = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        mosi_sync_d   = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        cs_sync_d     = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
        sclk_prev_d   = sclk_s;
        cs_prev_d     = cs_s;
        fill_d        = fill_done ? fill_q : fill_q + FILL_W'(1);
        // After reset the chains start deasserted, so a low cs_n pin would look like a
        // fresh falling edge; only arm once the settled pin has been seen high.
        armed_d       = armed_q | (fill_done & cs_s & cs_prev_q);
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        rx_shift_d    = rx_shift_q;
        tx_shift_d    = tx_shift_q;
        rx_data_d     = rx_data_q;
        word_cnt_d    = word_cnt_q;
        rx_valid_d    = 1'b0;
        tx_req_d      = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        frame_abort_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall && armed_q) begin
                    state_d       = ST_ACTIVE;
                    frame_start_d = 1'b1;
                    tx_req_d      = 1'b1;
                    bit_cnt_d     = '0;
                    word_cnt_d    = '0;
                    rx_shift_d    = '0;
                    tx_shift_d    = tx_data;
                end
            end
            default: begin
                // Chip-select release wins over a coincident sclk edge.
                if (cs_rise) begin
                    state_d       = ST_IDLE;
                    frame_end_d   = 1'b1;
                    frame_abort_d = (bit_cnt_q != '0);
                    bit_cnt_d     = '0;
                    rx_shift_d    = '0;
                end else if (sclk_rise) begin
                    rx_shift_d = rx_next;
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d  = '0;
                        rx_data_d  = rx_next;
                        rx_valid_d = 1'b1;
                        tx_req_d   = 1'b1;
                        if (word_cnt_q != CNT_MAX) begin
                            word_cnt_d = word_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end else if (sclk_fall) begin
                    if (bit_cnt_q == '0) begin
                        tx_shift_d = tx_data;
                    end else begin
                        tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync_q   <= '0;
            mosi_sync_q   <= '0;
            cs_sync_q     <= '1;
            sclk_prev_q   <= 1'b0;
            cs_prev_q     <= 1'b1;
            fill_q        <= '0;
            armed_q       <= 1'b0;
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            rx_shift_q    <= '0;
            tx_shift_q    <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            tx_req_q      <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            frame_abort_q <= 1'b0;
            word_cnt_q    <= '0;
        end else begin
            sclk_sync_q   <= sclk_sync_d;
            mosi_sync_q   <= mosi_sync_d;
            cs_sync_q     <= cs_sync_d;
            sclk_prev_q   <= sclk_prev_d;
            cs_prev_q     <= cs_prev_d;
            fill_q        <= fill_d;
            armed_q       <= armed_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_shift_q    <= rx_shift_d;
            tx_shift_q    <= tx_shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            tx_req_q      <= tx_req_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            frame_abort_q <= frame_abort_d;
            word_cnt_q    <= word_cnt_d;
        end
    end

    assign miso        = (state_q == ST_ACTIVE) ? tx_shift_q[DATA_W-1] : 1'b0;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_req      = tx_req_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign frame_abort = frame_abort_q;
    assign word_cnt    = word_cnt_q;

`ifdef SPI_OVERRUN_DETECT_EN
    logic rx_pending_q, rx_pending_d;
    logic rx_overrun_q, rx_overrun_d;

    // An ack in the same cycle as a new word only retires the old word.
    always_comb begin
        rx_pending_d = rx_pending_q;
        rx_overrun_d = rx_overrun_q;
        if (rx_valid_q) begin
            rx_pending_d = 1'b1;
            if (rx_pending_q && !rx_ack) begin
                rx_overrun_d = 1'b1;
            end
        end else if (rx_ack) begin
            rx_pending_d = 1'b0;
        end
        if (frame_start_q) begin
            rx_overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_pending_q <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else begin
            rx_pending_q <= rx_pending_d;
            rx_overrun_q <= rx_overrun_d;
        end
    end

    assign rx_overrun = rx_overrun_q;
`else
    logic unused_rx_ack;
    assign unused_rx_ack = rx_ack;
    assign rx_overrun    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_byte_if.sv
// Bench for spi_slave_byte_if: directed test-plan frames plus random frames, acting as SPI master
// and as the downstream controller; expectations come from the byte-level frame description.
module tb_spi_slave_byte_if;

    localparam int DW = 8;
    localparam int CW = 8;
`ifdef SPI_OVERRUN_DETECT_EN
    localparam logic OVR_EN = 1'b1;
`else
    localparam logic OVR_EN = 1'b0;
`endif

    logic          clk, rst_n, sclk, mosi, cs_n, miso;
    logic [DW-1:0] rx_data, tx_data;
    logic          rx_valid, rx_ack, tx_req, frame_start, frame_end, frame_abort, rx_overrun;
    logic [CW-1:0] word_cnt;

    spi_slave_byte_if #(.SYNC_STAGES(2), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .miso(miso),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack), .tx_data(tx_data),
        .tx_req(tx_req), .frame_start(frame_start), .frame_end(frame_end),
        .frame_abort(frame_abort), .word_cnt(word_cnt), .rx_overrun(rx_overrun)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int n_fs, n_fe, n_fa, n_fa_lone, n_txr;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] resp_q[$];
    logic [DW-1:0] resp_all[$];
    logic [DW-1:0] mosi_q[$];
    logic          miso_bits[$];
    logic [DW-1:0] last_rx = '0;
    logic          ack_en = 1'b1;
    logic          force_ack = 1'b0;
    logic          ack_sched = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        n_fs = 0; n_fe = 0; n_fa = 0; n_fa_lone = 0; n_txr = 0;
    endtask

    // Scoreboard and controller model, sampled mid-cycle
    always @(negedge clk) begin
        rx_ack    = ack_sched | force_ack;
        ack_sched = ack_en && (rx_valid === 1'b1);
        if (rx_valid === 1'b1) begin
            vectors++;
            assert (exp_q.size() != 0) else begin
                miscompares++;
                $error("FAIL rx_unexpected: observed rx_valid data %0h expected no word", rx_data);
            end
            if (exp_q.size() != 0) begin
                check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
            end
        end
        if (frame_start === 1'b1) n_fs++;
        if (frame_end === 1'b1) n_fe++;
        if (frame_abort === 1'b1) n_fa++;
        if (frame_abort === 1'b1 && frame_end !== 1'b1) n_fa_lone++;
        if (tx_req === 1'b1) n_txr++;
        if (tx_req === 1'b1 && frame_start !== 1'b1 && resp_q.size() > 0) tx_data = resp_q.pop_front();
    end

    task automatic half();
        repeat (5) @(negedge clk);
    endtask

    // SPI master, mode 0: MOSI changes while sclk is low, MISO sampled just before each rise
    task automatic spi_frame(input int nbits, input bit cs_with_last);
        logic [DW-1:0] b;
        miso_bits.delete();
        cs_n = 1'b0;
        half();
        check("ovr_clear_on_start", 32'(rx_overrun), 32'(0));
        for (int i = 0; i < nbits; i++) begin
            b = mosi_q[i / 8];
            mosi = b[7 - (i % 8)];
            half();
            miso_bits.push_back(miso);
            sclk = 1'b1;
            if (cs_with_last && i == nbits - 1) cs_n = 1'b1;
            half();
            sclk = 1'b0;
        end
        half();
        cs_n = 1'b1;
        half();
        half();
    endtask

    // One frame of `full` complete words plus `extra` trailing bits taken from mosi_q;
    // resp_all holds the controller's reply words, the first one presented before cs_n falls.
    task automatic do_frame(input int full, input int extra, input bit cs_with_last, input bit ack);
        logic [DW-1:0] b;
        int exp_cnt;
        clear_counts();
        ack_en = ack;
        tx_data = resp_all[0];
        resp_q.delete();
        for (int k = 1; k < resp_all.size(); k++) resp_q.push_back(resp_all[k]);
        for (int k = 0; k < full; k++) exp_q.push_back(mosi_q[k]);
        spi_frame(full * 8 + extra, cs_with_last);
        check("frame_start_cnt", 32'(n_fs), 32'(1));
        check("frame_end_cnt", 32'(n_fe), 32'(1));
        check("frame_abort_cnt", 32'(n_fa), 32'(extra != 0));
        check("abort_without_end", 32'(n_fa_lone), 32'(0));
        check("tx_req_cnt", 32'(n_txr), 32'(1 + full));
        check("rx_missing", 32'(exp_q.size()), 32'(0));
        exp_q.delete();
        if (full > 0) last_rx = mosi_q[full - 1];
        check("rx_data_final", 32'(rx_data), 32'(last_rx));
        exp_cnt = (full > 255) ? 255 : full;
        check("word_cnt", 32'(word_cnt), 32'(exp_cnt));
        for (int k = 0; k < full; k++) begin
            for (int j = 0; j < 8; j++) b[7 - j] = miso_bits[8 * k + j];
            check("miso_word", 32'(b), 32'(resp_all[k]));
        end
        check("rx_overrun", 32'(rx_overrun), 32'((!ack && full >= 2) ? OVR_EN : 1'b0));
        ack_en = 1'b1;
    endtask

    task automatic random_frame(input int full, input int extra);
        mosi_q.delete();
        resp_all.delete();
        for (int k = 0; k <= full; k++) begin
            mosi_q.push_back(DW'($urandom_range(0, 255)));
            resp_all.push_back(DW'($urandom_range(0, 255)));
        end
        do_frame(full, extra, 1'b0, 1'b1);
    endtask

    initial begin
        int bad;
        int full;
        int extra;
        logic [DW-1:0] b;
        rst_n = 1'b0; sclk = 1'b0; mosi = 1'b0; cs_n = 1'b1; rx_ack = 1'b0; tx_data = '0;
        clear_counts();
        repeat (5) @(negedge clk);
        check("reset_rx_data", 32'(rx_data), 32'(0));
        check("reset_word_cnt", 32'(word_cnt), 32'(0));
        check("reset_miso", 32'(miso), 32'(0));

        // Idle after reset: everything stays quiet for 1000 ns
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ({miso, rx_valid, tx_req, frame_start, frame_end, frame_abort, rx_overrun} !== 7'b0 ||
                rx_data !== '0 || word_cnt !== '0) bad++;
        end
        check("reset_quiet_cycles", 32'(bad), 32'(0));

        // Single word
        mosi_q = '{8'hA5};
        resp_all = '{8'hC3};
        do_frame(1, 0, 1'b0, 1'b1);

        // Three back-to-back words with controller replies
        mosi_q = '{8'h01, 8'h7E, 8'hFF};
        resp_all = '{8'hC3, 8'h10, 8'h20};
        do_frame(3, 0, 1'b0, 1'b1);

        // Abort after five bits, then a clean frame
        mosi_q = '{8'hF0};
        resp_all = '{8'h5A};
        do_frame(0, 5, 1'b0, 1'b1);
        mosi_q = '{8'h3C};
        resp_all = '{8'h66};
        do_frame(1, 0, 1'b0, 1'b1);

        // cs_n released together with the eighth sclk rise: the word is discarded
        mosi_q = '{8'hB7};
        resp_all = '{8'h81};
        do_frame(0, 8, 1'b1, 1'b1);

        // Reset during bit 4; the rest of that frame must be ignored
        tx_data = 8'h99;
        b = 8'hAA;
        cs_n = 1'b0;
        half();
        for (int i = 0; i < 8; i++) begin
            mosi = b[7 - i];
            half();
            sclk = 1'b1;
            if (i == 3) begin
                repeat (2) @(negedge clk);
                rst_n = 1'b0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                clear_counts();
                exp_q.delete();
                last_rx = '0;
                @(negedge clk);
            end else begin
                half();
            end
            sclk = 1'b0;
        end
        half();
        cs_n = 1'b1;
        half();
        half();
        check("rst_mid_frame_start", 32'(n_fs), 32'(0));
        check("rst_mid_frame_end", 32'(n_fe), 32'(0));
        check("rst_mid_tx_req", 32'(n_txr), 32'(0));
        check("rst_mid_rx_data", 32'(rx_data), 32'(0));
        check("rst_mid_word_cnt", 32'(word_cnt), 32'(0));
        mosi_q = '{8'h55};
        resp_all = '{8'h96};
        do_frame(1, 0, 1'b0, 1'b1);

        // Two words without acknowledgement
        mosi_q = '{8'h11, 8'h22};
        resp_all = '{8'h33, 8'h44};
        do_frame(2, 0, 1'b0, 1'b0);
        @(negedge clk);
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        random_frame(2, 0);

        // Random frames, some ending mid-word
        for (int f = 0; f < 8; f++) begin
            full = $urandom_range(0, 4);
            extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            if (full == 0 && extra == 0) full = 1;
            random_frame(full, extra);
        end

        // Word counter saturation
        random_frame(257, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
